fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch unit directly upstream of the combinational, byte-addressed, little-endian instruction memory.
- Owns the PC, drives the memory address, and captures the returned word with its PC into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Supports PC redirect (taken branch/jump) with flush, and halts when the fetch address runs past memory.

Parameters:
- RESET_PC, 0: PC value loaded at reset.
- FIFO_DEPTH, 2: entries in the fetch FIFO; power of two, minimum 2.
- IMEM_BYTES, 400: instruction memory size in bytes; fetch is legal only while pc+3 < IMEM_BYTES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_addr  output  32  byte address to instruction memory; equals pc combinationally.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  load a new PC and flush the FIFO this cycle.
- redirect_pc  input  32  target PC for the redirect.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_ins  output  32  head instruction; 0 when the FIFO is empty.
- out_pc  output  32  PC of the head instruction; 0 when the FIFO is empty.
- halted  output  1  fetch stopped on an out-of-range address.
- fetch_err  output  1  misaligned redirect error (driven 0 when the feature is compiled out).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, FIFO empty, state=FETCH.
  - out_valid=0, out_ins=0, out_pc=0, halted=0, fetch_err=0.
- States: FETCH, HALT, ERR (ERR exists only with the optional feature).
- pop = out_valid && out_ready.
- push is allowed when state=FETCH && !redirect_valid && in_range && (count<FIFO_DEPTH || pop).
  - in_range = (pc + 3 < IMEM_BYTES), computed in 33 bits so there is no wrap.
- On push: write {pc, imem_data} at the tail; pc <= pc + 4, modulo 2^32.
- Latency: a word is written at the edge ending the cycle pc was presented; out_valid rises the next cycle. No combinational path from imem_data to out_*.
- Full FIFO with no pop: pc holds, no push; imem_addr keeps showing pc.
- Full FIFO with a pop in the same cycle: push and pop both occur; count is unchanged.
- Empty FIFO: out_valid=0; out_ready is ignored.
- FETCH with !in_range and no redirect:
  - next state HALT, halted=1, pc holds.
  - Entries already in the FIFO still drain normally.
- Redirect (any state except ERR), priority over everything else:
  - FIFO cleared (count=0), including a head presented in that same cycle; that head is not considered consumed even if out_ready=1.
  - pc <= aligned redirect_pc; state <= FETCH; halted <= 0; no push this cycle.
  - out_valid is 0 the next cycle.
- Back-to-back redirects: the last one wins; the FIFO stays empty.
- Reset asserted mid-operation: immediate return to reset values, and all FIFO contents are discarded.
- Count width is clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 goes to state ERR, sets fetch_err=1, flushes the FIFO, and leaves pc unchanged.
  - In ERR there are no pushes, redirects are ignored, and fetch_err is sticky until reset.
  - Aligned redirects behave as specified above.
- Not defined:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - fetch_err is tied to 0 and ERR is unreachable.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, memory holding 0x000010B7 / 0x00002137 / 0x00114463 -> out_valid rises 1 cycle after reset release; (out_pc, out_ins) = (0, 0x000010B7), (4, 0x00002137), (8, 0x00114463) on consecutive cycles.
- out_ready=0 for 5 cycles from reset -> FIFO fills with pc 0 and 4; imem_addr holds 8; raising out_ready drains 0, 4, then 8 with no gap.
- redirect_valid=1, redirect_pc=0x14 while the FIFO holds 2 entries and out_ready=1 -> next cycle out_valid=0; following cycle out_pc=0x14 and out_ins=0x10008093.
- IMEM_BYTES=24, free-running -> last pushed pc=0x14; halted=1 with pc=0x18; then redirect to 0 -> halted=0 and fetch resumes at 0.
- rst_n pulsed low mid-stream with 2 entries queued -> out_valid=0 immediately (asynchronous); after release fetch restarts at RESET_PC.
- FETCH_MISALIGN_EN defined, redirect_pc=0x0A -> fetch_err=1 sticky, out_valid=0, a later redirect to 0x10 ignored. Macro undefined, same stimulus -> next out_pc=0x08.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and queues {pc, word} for decode.
// Optional FETCH_MISALIGN_EN: a misaligned redirect traps into a sticky error state instead of being truncated.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_BYTES = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fetch_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       pc;
    logic [31:0]       pc_mem  [FIFO_DEPTH];
    logic [31:0]       ins_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              in_range;
    logic              redir_take;
    logic              redir_bad;
    logic              fifo_full;
    logic              pop;
    logic              push;

    assign imem_addr = pc;

    // 33-bit compare so a PC near 2^32 cannot wrap back into range
    assign in_range   = ({1'b0, pc} + 33'd3) < 33'(IMEM_BYTES);
    assign redir_take = redirect_valid && (state != S_ERR);

`ifdef FETCH_MISALIGN_EN
    assign redir_bad = redir_take && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    // A head presented during a redirect is flushed, not consumed
    assign pop       = out_valid && out_ready && !redir_take;
    assign push      = (state == S_FETCH) && !redirect_valid && in_range && (!fifo_full || pop);

    assign out_ins = out_valid ? ins_mem[rd_ptr] : 32'h0;
    assign out_pc  = out_valid ? pc_mem[rd_ptr]  : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (redir_take) begin
                    state_nxt = redir_bad ? S_ERR : S_FETCH;
                end else if (!in_range) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (redir_take) begin
                    state_nxt = redir_bad ? S_ERR : S_FETCH;
                end
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        halted = (state == S_HALT);
`ifdef FETCH_MISALIGN_EN
        fetch_err = (state == S_ERR);
`else
        fetch_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redir_take) begin
            if (!redir_bad) begin
                pc <= redirect_pc & 32'hFFFF_FFFC;
            end
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redir_take) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= pc;
            ins_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed redirect/halt/reset/misalign sequences against a 24-byte memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        halted;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb_q[$];
    logic [31:0] imem [0:5];

    fetch_stage #(
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(2),
        .IMEM_BYTES(24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ins       (out_ins),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        imem[0] = 32'h000010B7;
        imem[1] = 32'h00002137;
        imem[2] = 32'h00114463;
        imem[3] = 32'h00308193;
        imem[4] = 32'h00410213;
        imem[5] = 32'h10008093;
    end

    always_comb begin
        imem_data = 32'hDEADBEEF;
        if (imem_addr < 32'd24) begin
            imem_data = imem[imem_addr[4:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        sb_q.push_back({pc, imem[pc[4:2]]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted transfer must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_transfer_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("xfer_pc", out_pc, e[63:32]);
                check("xfer_ins", out_ins, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_ins", out_ins, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // Free run from reset through to the out-of-range halt
        for (int a = 0; a < 24; a += 4) expect_word(32'(a));
        tick();
        tick();
        rst_n = 1'b1;
        check("first_cycle_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("second_cycle_out_valid", {31'b0, out_valid}, 32'd1);
        repeat (10) tick();
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_imem_addr", imem_addr, 32'h18);
        check("halt_out_valid", {31'b0, out_valid}, 32'd0);
        check("halt_drained", 32'(sb_q.size()), 32'd0);

        // Redirect out of halt with decode stalled: FIFO fills, pc parks at 8
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("resume_halted", {31'b0, halted}, 32'd0);
        repeat (4) tick();
        check("full_imem_addr", imem_addr, 32'h8);
        check("full_out_pc", out_pc, 32'h0);
        check("full_out_ins", out_ins, 32'h000010B7);

        // Drain 0,4,8 back to back, then redirect to 0x14 with two entries queued
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'h14);
        out_ready = 1'b1;
        repeat (3) tick();
        check("pre_redirect_out_pc", out_pc, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        tick();
        redirect_valid = 1'b0;
        check("post_redirect_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("redirect_target_pc", out_pc, 32'h14);
        check("redirect_target_ins", out_ins, 32'h10008093);
        repeat (4) tick();
        check("redirect_halted", {31'b0, halted}, 32'd1);
        check("redirect_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-stream with two entries queued
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        check("prereset_out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_out_pc", out_pc, 32'h0);
        check("async_rst_imem_addr", imem_addr, 32'h0);
        out_ready = 1'b1;
        for (int a = 0; a < 24; a += 4) expect_word(32'(a));
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("restart_drained", 32'(sb_q.size()), 32'd0);
        check("restart_halted", {31'b0, halted}, 32'd1);

        // Misaligned redirect to 0x0A, then a later redirect to 0x10
`ifndef FETCH_MISALIGN_EN
        for (int a = 8; a < 24; a += 4) expect_word(32'(a));
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0A;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
        check("misalign_fetch_err", {31'b0, fetch_err}, 32'd1);
        check("misalign_imem_addr", imem_addr, 32'h18);
        check("misalign_out_valid", {31'b0, out_valid}, 32'd0);
`else
        check("misalign_fetch_err", {31'b0, fetch_err}, 32'd0);
        check("misalign_imem_addr", imem_addr, 32'h8);
`endif
        repeat (8) tick();
`ifndef FETCH_MISALIGN_EN
        check("misalign_drained", 32'(sb_q.size()), 32'd0);
        expect_word(32'h10);
        expect_word(32'h14);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
`ifdef FETCH_MISALIGN_EN
        check("err_sticky", {31'b0, fetch_err}, 32'd1);
        check("err_redirect_ignored", imem_addr, 32'h18);
        check("err_out_valid", {31'b0, out_valid}, 32'd0);
`else
        check("late_redirect_drained", 32'(sb_q.size()), 32'd0);
        check("late_redirect_halted", {31'b0, halted}, 32'd1);
        check("late_fetch_err", {31'b0, fetch_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
